// File: rtl/control_sequencer.sv
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Hardwired fetch/execute sequencer (T0..T5) driving the Datapath
//             register enables, bus selects, MDR read, PC increment, ALU op.
//  Options  : CTRL_MULDIV_EN adds mul/div (opcodes 15/16) and state T6.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
   parameter int ALU_OP_W = 5,
   parameter int NUM_GPR  = 16
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                start,
   input  logic                halt_req,
   input  logic [31:0]         ir,
   output logic [31:0]         enable,
   output logic [31:0]         busSelect,
   output logic                md_read,
   output logic                inc_pc,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                busy,
   output logic                done,
   output logic                illegal
);

   localparam logic [3:0] c_ST_IDLE = 4'd0;
   localparam logic [3:0] c_ST_T0   = 4'd1;
   localparam logic [3:0] c_ST_T1   = 4'd2;
   localparam logic [3:0] c_ST_T2   = 4'd3;
   localparam logic [3:0] c_ST_T3   = 4'd4;
   localparam logic [3:0] c_ST_T4   = 4'd5;
   localparam logic [3:0] c_ST_T5   = 4'd6;
   localparam logic [3:0] c_ST_ERR  = 4'd7;
   localparam logic [3:0] c_ST_T6   = 4'd8;

   // Bit positions shared by enable and busSelect
   localparam int c_BIT_HI    = 16;
   localparam int c_BIT_LO    = 17;
   localparam int c_BIT_ZHIGH = 18;
   localparam int c_BIT_ZLOW  = 19;
   localparam int c_BIT_PC    = 20;
   localparam int c_BIT_MDR   = 21;
   localparam int c_BIT_IR    = 23;
   localparam int c_BIT_Z     = 24;
   localparam int c_BIT_MAR   = 25;
   localparam int c_BIT_Y     = 27;

   localparam logic [31:0] c_GPR_MASK = 32'((64'd1 << NUM_GPR) - 64'd1);

   logic [3:0]          r_state;
   logic [3:0]          w_next;
   logic [4:0]          w_opcode;
   logic [3:0]          w_ra;
   logic [3:0]          w_rb;
   logic [3:0]          w_rc;
   logic                w_legal;
   logic                w_is_muldiv;
   logic [31:0]         w_enable;
   logic [31:0]         w_bus_select;
   logic                w_md_read;
   logic                w_inc_pc;
   logic [ALU_OP_W-1:0] w_alu_op;
   logic                w_busy;
   logic                w_done;
   logic                w_illegal;
   logic                w_unused;

   assign w_opcode = ir[31:27];
   assign w_ra     = ir[26:23];
   assign w_rb     = ir[22:19];
   assign w_rc     = ir[18:15];
   // Immediate/constant field is not used by the supported instruction set
   assign w_unused = ^ir[14:0];

   always_comb begin
      w_legal = 1'b0;
      case (w_opcode)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
         5'd8, 5'd9, 5'd10, 5'd11: w_legal = 1'b1;
`ifdef CTRL_MULDIV_EN
         5'd15, 5'd16:             w_legal = 1'b1;
`endif
         default:                  w_legal = 1'b0;
      endcase
   end

`ifdef CTRL_MULDIV_EN
   assign w_is_muldiv = (w_opcode == 5'd15) || (w_opcode == 5'd16);
`else
   assign w_is_muldiv = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE: if (start) w_next = c_ST_T0;
         c_ST_T0:   w_next = c_ST_T1;
         c_ST_T1:   w_next = c_ST_T2;
         // Decode must happen here since T3 outputs are registered from it
         c_ST_T2:   w_next = w_legal ? c_ST_T3 : c_ST_ERR;
         c_ST_T3:   w_next = c_ST_T4;
         c_ST_T4:   w_next = c_ST_T5;
         c_ST_T5: begin
            if (w_is_muldiv)   w_next = c_ST_T6;
            else if (halt_req) w_next = c_ST_IDLE;
            else               w_next = c_ST_T0;
         end
         c_ST_T6:   w_next = halt_req ? c_ST_IDLE : c_ST_T0;
         c_ST_ERR:  w_next = c_ST_ERR;
         default:   w_next = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_enable     = '0;
      w_bus_select = '0;
      w_md_read    = 1'b0;
      w_inc_pc     = 1'b0;
      w_alu_op     = '0;
      w_done       = 1'b0;
      w_illegal    = 1'b0;
      w_busy       = (w_next != c_ST_IDLE) && (w_next != c_ST_ERR);
      case (w_next)
         c_ST_T0: begin
            w_bus_select[c_BIT_PC] = 1'b1;
            w_enable[c_BIT_MAR]    = 1'b1;
            w_enable[c_BIT_Z]      = 1'b1;
            w_inc_pc               = 1'b1;
         end
         c_ST_T1: begin
            w_bus_select[c_BIT_ZLOW] = 1'b1;
            w_enable[c_BIT_PC]       = 1'b1;
            w_enable[c_BIT_MDR]      = 1'b1;
            w_md_read                = 1'b1;
         end
         c_ST_T2: begin
            w_bus_select[c_BIT_MDR] = 1'b1;
            w_enable[c_BIT_IR]      = 1'b1;
         end
         c_ST_T3: begin
            w_bus_select       = (32'd1 << w_rb) & c_GPR_MASK;
            w_enable[c_BIT_Y]  = 1'b1;
         end
         c_ST_T4: begin
            w_bus_select       = (32'd1 << w_rc) & c_GPR_MASK;
            w_enable[c_BIT_Z]  = 1'b1;
            w_alu_op           = ALU_OP_W'(w_opcode);
         end
         c_ST_T5: begin
            w_bus_select[c_BIT_ZLOW] = 1'b1;
            if (w_is_muldiv) begin
               w_enable[c_BIT_LO] = 1'b1;
            end else begin
               w_enable = (32'd1 << w_ra) & c_GPR_MASK;
               w_done   = 1'b1;
            end
         end
         c_ST_T6: begin
            w_bus_select[c_BIT_ZHIGH] = 1'b1;
            w_enable[c_BIT_HI]        = 1'b1;
            w_done                    = 1'b1;
         end
         c_ST_ERR: w_illegal = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state   <= c_ST_IDLE;
         enable    <= '0;
         busSelect <= '0;
         md_read   <= 1'b0;
         inc_pc    <= 1'b0;
         alu_op    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         r_state   <= w_next;
         enable    <= w_enable;
         busSelect <= w_bus_select;
         md_read   <= w_md_read;
         inc_pc    <= w_inc_pc;
         alu_op    <= w_alu_op;
         busy      <= w_busy;
         done      <= w_done;
         illegal   <= w_illegal;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Randomized scoreboard bench for control_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr;
   logic        start;
   logic        halt_req;
   logic [31:0] ir;
   logic [31:0] enable;
   logic [31:0] busSelect;
   logic        md_read;
   logic        inc_pc;
   logic [4:0]  alu_op;
   logic        busy;
   logic        done;
   logic        illegal;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .halt_req  (halt_req),
      .ir        (ir),
      .enable    (enable),
      .busSelect (busSelect),
      .md_read   (md_read),
      .inc_pc    (inc_pc),
      .alu_op    (alu_op),
      .busy      (busy),
      .done      (done),
      .illegal   (illegal)
   );

   typedef struct packed {
      logic [31:0] en;
      logic [31:0] bus;
      logic        md;
      logic        inc;
      logic [4:0]  op;
      logic        bsy;
      logic        dn;
      logic        ill;
   } rec_t;

   rec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] b(input int n);
      return 32'd1 << n;
   endfunction

   function automatic bit op_legal(input int op);
      if (op >= 3 && op <= 11) return 1'b1;
`ifdef CTRL_MULDIV_EN
      if (op == 15 || op == 16) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic bit op_muldiv(input int op);
`ifdef CTRL_MULDIV_EN
      return (op == 15 || op == 16);
`else
      return 1'b0;
`endif
   endfunction

   function automatic rec_t mk(input logic [31:0] en, input logic [31:0] bus,
                               input bit md, input bit inc, input int op,
                               input bit bsy, input bit dn, input bit ill);
      rec_t r;
      r.en = en; r.bus = bus; r.md = md; r.inc = inc; r.op = 5'(op);
      r.bsy = bsy; r.dn = dn; r.ill = ill;
      return r;
   endfunction

   function automatic rec_t sample();
      return mk(enable, busSelect, md_read, inc_pc, int'(alu_op), busy, done, illegal);
   endfunction

   // Reference: the list of per-cycle outputs one instruction produces
   task automatic push_instr(input logic [31:0] instr, input int limit,
                             output int n, output bit bad);
      rec_t seq[$];
      int op, ra, rb, rc;
      op = int'(instr[31:27]);
      ra = int'(instr[26:23]);
      rb = int'(instr[22:19]);
      rc = int'(instr[18:15]);
      bad = 1'b0;
      seq.push_back(mk(b(25) | b(24), b(20), 0, 1, 0, 1, 0, 0));
      seq.push_back(mk(b(20) | b(21), b(19), 1, 0, 0, 1, 0, 0));
      seq.push_back(mk(b(23),         b(21), 0, 0, 0, 1, 0, 0));
      if (!op_legal(op)) begin
         bad = 1'b1;
         seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
      end else begin
         seq.push_back(mk(b(27), b(rb), 0, 0, 0,  1, 0, 0));
         seq.push_back(mk(b(24), b(rc), 0, 0, op, 1, 0, 0));
         if (op_muldiv(op)) begin
            seq.push_back(mk(b(17), b(19), 0, 0, 0, 1, 0, 0));
            seq.push_back(mk(b(16), b(18), 0, 0, 0, 1, 1, 0));
         end else begin
            seq.push_back(mk(b(ra), b(19), 0, 0, 0, 1, 1, 0));
         end
      end
      n = 0;
      foreach (seq[i]) begin
         if (i < limit) begin
            exp_q.push_back(seq[i]);
            n++;
         end
      end
   endtask

   // Monitor: every cycle the DUT reports activity, pop and compare
   always @(negedge clk) begin
      if (busy === 1'b1 || illegal === 1'b1) begin
         rec_t a, e;
         a = sample();
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_activity: got %h required idle", a);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               errors++;
               $display("FAIL cycle_outputs: got %h required %h", a, e);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_check(input string name);
      rec_t a;
      a = sample();
      checks++;
      if (a !== '0) begin
         errors++;
         $display("FAIL %s: got %h required all zero", name, a);
      end
   endtask

   // Caller is in the cycle before T0 (IDLE, or T5/T6 of previous instruction)
   task automatic exec(input logic [31:0] instr, input bit halt,
                       input bit from_idle, output bit bad);
      int n;
      push_instr(instr, 99, n, bad);
      if (bad) for (int k = 0; k < 3; k++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
      if (from_idle) start = 1'b1;
      step();
      ir = instr;
      start = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      for (int k = 1; k < n; k++) begin
         step();
         start = 1'($urandom_range(0, 1));
         halt_req = (k == n - 1) ? halt : 1'($urandom_range(0, 1));
      end
      if (bad) begin
         for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            step();
         end
         start = 1'b0;
         clr = 1'b1;
         #1;
         idle_check("clr_clears_err");
         step();
         clr = 1'b0;
         idle_check("idle_after_err_clr");
      end
   endtask

   task automatic clr_mid_instr(input logic [31:0] instr);
      int n;
      bit bad;
      push_instr(instr, 5, n, bad);
      start = 1'b1;
      step();
      ir = instr;
      start = 1'b0;
      halt_req = 1'b0;
      repeat (4) step();
      clr = 1'b1;
      #1;
      idle_check("async_clr_in_t4");
      step();
      idle_check("clr_held");
      clr = 1'b0;
      step();
      idle_check("no_ra_write_after_clr");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] prog[$];
      bit          halts[$];
      bit          in_idle;
      bit          bad;
      logic [31:0] instr;

      clr = 1'b1; start = 1'b0; halt_req = 1'b0; ir = '0;
      repeat (3) step();
      idle_check("reset_state");
      clr = 1'b0;
      repeat (10) begin
         step();
         idle_check("idle_no_start");
      end

      prog.push_back(32'h389A8000); halts.push_back(1'b1);
      repeat (3) begin prog.push_back(32'h19230000); halts.push_back(1'b0); end
      prog.push_back(32'h19230000); halts.push_back(1'b1);
      prog.push_back(32'h00000000); halts.push_back(1'b0);
      prog.push_back(32'h7819A800); halts.push_back(1'b1);
      prog.push_back(32'h08000000 | (32'd9 << 27)); halts.push_back(1'b0);
      for (int i = 0; i < 40; i++) begin
         int op;
         op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                          : int'($urandom_range(3, 11));
         instr = $urandom;
         instr[31:27] = 5'(op);
         prog.push_back(instr);
         halts.push_back(i == 39 ? 1'b1 : ($urandom_range(0, 3) == 0));
      end

      in_idle = 1'b1;
      foreach (prog[i]) begin
         exec(prog[i], halts[i], in_idle, bad);
         if (bad) begin
            in_idle = 1'b1;
         end else if (halts[i]) begin
            step();
            start = 1'b0;
            idle_check("halt_returns_idle");
            in_idle = 1'b1;
         end else begin
            in_idle = 1'b0;
         end
         if (i == 2) begin
            // Mid-program reset only applies from IDLE
            if (in_idle) clr_mid_instr(32'h389A8000);
         end
      end
      if (!in_idle) begin
         halt_req = 1'b1;
         step();
         start = 1'b0;
      end
      clr_mid_instr(32'h19230000);

      repeat (3) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drained: got %0d pending required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
